// File: rtl/fir_out_conditioner.sv
// fir_out_conditioner: output stage behind the 51-tap band-pass FIR.
// The full-precision filter output is requantised to OUT_W bits with
// round-half-up and saturation. Clip events go into a sticky counter.
// The peak |y_out| is measured over windows of WIN valid samples and drives
// a hysteretic tone-present detector.
//
// Pipeline:
//   p0  combinational round + saturate of y_in
//   p1  registered sample (y_out / sat_flag / y_valid), clip counter
//   p2  window peak register and peak_valid pulse
//   p3  tone FSM and registered tone_det
module fir_out_conditioner #(
    parameter int IN_W   = 38,
    parameter int OUT_W  = 16,
    parameter int SHIFT  = 15,
    parameter int WIN    = 64,
    parameter int TH_ON  = 4000,
    parameter int TH_OFF = 2000,
    parameter int HOLD   = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    input  logic signed [IN_W-1:0]  y_in,
    output logic signed [OUT_W-1:0] y_out,
    output logic                    y_valid,
    output logic                    sat_flag,
    output logic [OUT_W-1:0]        peak,
    output logic                    peak_valid,
    output logic                    tone_det,
    output logic [15:0]             sat_count
);

    // Requantiser constants. Every value is at IN_W+1 bits, so the
    // rounding add cannot overflow.
    localparam logic signed [IN_W:0] HALF =
        (IN_W+1)'(1) <<< (SHIFT - 1);
    localparam logic signed [IN_W:0] SAT_HI =
        {{(IN_W+2-OUT_W){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [IN_W:0] SAT_LO =
        {{(IN_W+2-OUT_W){1'b1}}, {(OUT_W-1){1'b0}}};

    // The most negative output has no positive counterpart. Its magnitude
    // is clamped to the largest positive value.
    localparam logic signed [OUT_W-1:0] OUT_MIN = {1'b1, {(OUT_W-1){1'b0}}};
    localparam logic [OUT_W-1:0]        MAG_MAX = {1'b0, {(OUT_W-1){1'b1}}};

    // Window and hysteresis constants.
    localparam int                CNT_W     = $clog2(WIN);
    localparam logic [CNT_W-1:0]  WIN_LAST  = CNT_W'(WIN - 1);
    localparam int                HOLD_W    = $clog2(HOLD + 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD - 1);
    localparam logic [OUT_W-1:0]  TH_ON_V   = OUT_W'(TH_ON);
    localparam logic [OUT_W-1:0]  TH_OFF_V  = OUT_W'(TH_OFF);
    localparam logic [15:0]       CNT_MAX   = 16'hFFFF;

    typedef enum logic [1:0] {
        ABSENT    = 2'd0,
        ARMING    = 2'd1,
        PRESENT   = 2'd2,
        RELEASING = 2'd3
    } tone_st_t;

    // Round half up: add half an LSB of the result, then shift arithmetically.
    function automatic logic signed [IN_W:0] round_shift(
        input logic signed [IN_W-1:0] x
    );
        logic signed [IN_W:0] sum;
        sum = $signed({x[IN_W-1], x}) + HALF;
        return sum >>> SHIFT;
    endfunction

    // Clamp to OUT_W signed. Returns {clipped, value}.
    function automatic logic [OUT_W:0] saturate(
        input logic signed [IN_W:0] r
    );
        if (r > SAT_HI) begin
            return {1'b1, SAT_HI[OUT_W-1:0]};
        end else if (r < SAT_LO) begin
            return {1'b1, SAT_LO[OUT_W-1:0]};
        end else begin
            return {1'b0, r[OUT_W-1:0]};
        end
    endfunction

    // Unsigned magnitude of a requantised sample, clamped at MAG_MAX.
    function automatic logic [OUT_W-1:0] magnitude(
        input logic signed [OUT_W-1:0] v
    );
        logic signed [OUT_W-1:0] neg;
        neg = -v;
        if (v == OUT_MIN) begin
            return MAG_MAX;
        end else if (v[OUT_W-1]) begin
            return neg;
        end else begin
            return v;
        end
    endfunction

    // ---------------- stage p0 -> p1 : requantise ----------------
    logic [OUT_W:0]           q_p0;
    logic signed [OUT_W-1:0]  y_p1;
    logic                     sat_p1;
    logic                     vld_p1;
    logic [15:0]              sat_cnt;

    assign q_p0 = saturate(round_shift(y_in));

    // Register the requantised sample. Data holds when no new sample arrives.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            y_p1   <= '0;
            sat_p1 <= 1'b0;
            vld_p1 <= 1'b0;
        end else begin
            vld_p1 <= in_valid;
            if (in_valid) begin
                sat_p1 <= q_p0[OUT_W];
                y_p1   <= q_p0[OUT_W-1:0];
            end
        end
    end

    // Count clipped output samples. The count sticks at all-ones.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sat_cnt <= '0;
        end else if (vld_p1 && sat_p1 && (sat_cnt != CNT_MAX)) begin
            sat_cnt <= sat_cnt + 16'd1;
        end
    end

    // ---------------- stage p1 -> p2 : window peak ----------------
    logic [OUT_W-1:0] mag_p1;
    logic [OUT_W-1:0] wmax_p1;
    logic [OUT_W-1:0] run_max;
    logic [CNT_W-1:0] win_cnt;
    logic [OUT_W-1:0] peak_p2;
    logic             vld_p2;

    assign mag_p1  = magnitude(y_p1);
    assign wmax_p1 = (mag_p1 > run_max) ? mag_p1 : run_max;

    // Track the running max over WIN valid samples. Gaps in valid stall the
    // window. The last sample publishes the peak and starts a new window.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            run_max <= '0;
            win_cnt <= '0;
            peak_p2 <= '0;
            vld_p2  <= 1'b0;
        end else begin
            vld_p2 <= 1'b0;
            if (vld_p1) begin
                if (win_cnt == WIN_LAST) begin
                    peak_p2 <= wmax_p1;
                    vld_p2  <= 1'b1;
                    run_max <= '0;
                    win_cnt <= '0;
                end else begin
                    run_max <= wmax_p1;
                    win_cnt <= win_cnt + CNT_W'(1);
                end
            end
        end
    end

    // ---------------- stage p2 -> p3 : tone detector ----------------
    tone_st_t          tone_st;
    logic [HOLD_W-1:0] hold;
    logic              tone_p3;
    logic              is_on;
    logic              is_off;

    assign is_on  = (peak_p2 >= TH_ON_V);
    assign is_off = (peak_p2 <  TH_OFF_V);

    // Hysteretic tone FSM, stepped once per published peak. tone_p3 is
    // loaded with the destination state's indication, so it changes
    // in the cycle after the deciding peak_valid.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tone_st <= ABSENT;
            hold    <= '0;
            tone_p3 <= 1'b0;
        end else if (vld_p2) begin
            case (tone_st)
                ABSENT: begin
                    if (is_on) begin
                        hold <= HOLD_W'(1);
                        if (HOLD == 1) begin
                            tone_st <= PRESENT;
                            tone_p3 <= 1'b1;
                        end else begin
                            tone_st <= ARMING;
                        end
                    end
                end
                ARMING: begin
                    if (is_on) begin
                        hold <= hold + HOLD_W'(1);
                        if (hold >= HOLD_LAST) begin
                            tone_st <= PRESENT;
                            tone_p3 <= 1'b1;
                        end
                    end else begin
                        hold    <= '0;
                        tone_st <= ABSENT;
                    end
                end
                PRESENT: begin
                    if (is_off) begin
                        hold <= HOLD_W'(1);
                        if (HOLD == 1) begin
                            tone_st <= ABSENT;
                            tone_p3 <= 1'b0;
                        end else begin
                            tone_st <= RELEASING;
                        end
                    end
                end
                RELEASING: begin
                    if (is_off) begin
                        hold <= hold + HOLD_W'(1);
                        if (hold >= HOLD_LAST) begin
                            tone_st <= ABSENT;
                            tone_p3 <= 1'b0;
                        end
                    end else begin
                        hold    <= '0;
                        tone_st <= PRESENT;
                    end
                end
                default: begin
                    hold    <= '0;
                    tone_st <= ABSENT;
                    tone_p3 <= 1'b0;
                end
            endcase
        end
    end

    assign y_out      = y_p1;
    assign sat_flag   = sat_p1;
    assign y_valid    = vld_p1;
    assign sat_count  = sat_cnt;
    assign peak       = peak_p2;
    assign peak_valid = vld_p2;
    assign tone_det   = tone_p3;

endmodule

// File: tb/tb_fir_out_conditioner.sv
// Scoreboard testbench for fir_out_conditioner.
// The stimulus side evaluates the behavioural model and queues the expected
// samples and peaks. A monitor on the falling edge pops and compares them.
module tb_fir_out_conditioner;

    localparam int IN_W   = 38;
    localparam int OUT_W  = 16;
    localparam int SHIFT  = 15;
    localparam int WIN    = 64;
    localparam int TH_ON  = 4000;
    localparam int TH_OFF = 2000;
    localparam int HOLD   = 2;
    localparam longint ONE = 1;

    logic                    clk = 1'b0;
    logic                    rst = 1'b1;
    logic                    in_valid = 1'b0;
    logic signed [IN_W-1:0]  y_in = '0;
    logic signed [OUT_W-1:0] y_out;
    logic                    y_valid;
    logic                    sat_flag;
    logic [OUT_W-1:0]        peak;
    logic                    peak_valid;
    logic                    tone_det;
    logic [15:0]             sat_count;

    fir_out_conditioner #(
        .IN_W(IN_W), .OUT_W(OUT_W), .SHIFT(SHIFT), .WIN(WIN),
        .TH_ON(TH_ON), .TH_OFF(TH_OFF), .HOLD(HOLD)
    ) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .y_in(y_in),
        .y_out(y_out), .y_valid(y_valid), .sat_flag(sat_flag),
        .peak(peak), .peak_valid(peak_valid), .tone_det(tone_det),
        .sat_count(sat_count)
    );

    always #5 clk = ~clk;

    typedef struct { longint y; bit sat; } ys_t;
    typedef struct { longint pk; bit tone; } pk_t;

    ys_t yq[$];
    pk_t pq[$];

    int checks = 0;
    int errors = 0;
    int n_peak_seen = 0;

    // behavioural model state (stimulus side)
    int     m_cnt    = 0;
    longint m_max    = 0;
    bit     m_tone   = 0;
    int     m_streak = 0;
    int     m_clips  = 0;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Tone hysteresis: HOLD consecutive qualifying windows flip the state.
    task automatic tone_model(input longint pk);
        bit qual;
        qual = m_tone ? (pk < TH_OFF) : (pk >= TH_ON);
        m_streak = qual ? m_streak + 1 : 0;
        if (m_streak == HOLD) begin
            m_tone   = !m_tone;
            m_streak = 0;
        end
    endtask

    // Drive one valid sample and record what the DUT must produce for it.
    task automatic send(input longint x);
        longint r, y, m;
        bit     s;
        r = (x + (ONE << (SHIFT - 1))) >>> SHIFT;
        s = 1'b0;
        y = r;
        if (r > 32767)  begin y = 32767;  s = 1'b1; end
        if (r < -32768) begin y = -32768; s = 1'b1; end
        if (s) m_clips++;
        yq.push_back('{y: y, sat: s});
        m = (y < 0) ? -y : y;
        if (m > 32767) m = 32767;
        if (m > m_max) m_max = m;
        m_cnt++;
        if (m_cnt == WIN) begin
            tone_model(m_max);
            pq.push_back('{pk: m_max, tone: m_tone});
            m_cnt = 0;
            m_max = 0;
        end
        in_valid = 1'b1;
        y_in     = x[IN_W-1:0];
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic maybe_gap(input bit gaps);
        if (gaps && ($urandom_range(0, 3) == 0)) idle($urandom_range(1, 3));
    endtask

    // One window whose largest magnitude is exactly pk.
    task automatic window_of(input longint pk, input bit gaps);
        int     pos;
        longint lo, hi;
        pos = $urandom_range(0, WIN - 1);
        lo  = -pk * 32768;
        hi  = pk * 32768 + 16383;
        for (int i = 0; i < WIN; i++) begin
            if (i == pos)
                send(($urandom_range(0, 1) == 1) ? -pk * 32768 : pk * 32768);
            else
                send(lo + longint'($urandom_range(0, 32'(hi - lo))));
            maybe_gap(gaps);
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_y_out"},      y_out,      0);
        check({tag, "_y_valid"},    y_valid,    0);
        check({tag, "_sat_flag"},   sat_flag,   0);
        check({tag, "_peak"},       peak,       0);
        check({tag, "_peak_valid"}, peak_valid, 0);
        check({tag, "_tone_det"},   tone_det,   0);
        check({tag, "_sat_count"},  sat_count,  0);
    endtask

    task automatic model_reset();
        yq.delete();
        pq.delete();
        m_cnt = 0; m_max = 0; m_tone = 0; m_streak = 0; m_clips = 0;
    endtask

    // Monitor: compare every presented output against the queued expectations.
    bit     tone_pend = 0;
    bit     tone_next = 0;
    bit     exp_tone  = 0;
    longint exp_sat   = 0;

    always @(negedge clk) begin
        if (!rst) begin
            tone_pend = 0;
            exp_tone  = 0;
            exp_sat   = 0;
        end else begin
            ys_t e;
            pk_t p;
            if (tone_pend) begin
                exp_tone  = tone_next;
                tone_pend = 0;
            end
            check("tone_det", tone_det, exp_tone);
            check("sat_count", sat_count, exp_sat);
            if (y_valid) begin
                if (yq.size() == 0) begin
                    check("y_valid_unexpected", 1, 0);
                end else begin
                    e = yq.pop_front();
                    check("y_out", y_out, e.y);
                    check("sat_flag", sat_flag, e.sat);
                    if (e.sat && exp_sat < 65535) exp_sat++;
                end
            end
            if (peak_valid) begin
                n_peak_seen++;
                if (pq.size() == 0) begin
                    check("peak_valid_unexpected", 1, 0);
                end else begin
                    p = pq.pop_front();
                    check("peak", peak, p.pk);
                    tone_pend = 1;
                    tone_next = p.tone;
                end
            end
        end
    end

    initial begin
        int p0;
        longint raw;

        // reset at start-up, asynchronously before any clock edge
        #1 rst = 1'b0;
        #2 check_zero("rst_init");
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        idle(2);

        // rounding
        send(49152);   check("round_pos", y_out, 2);  check("round_pos_sat", sat_flag, 0);
        send(-49152);  check("round_neg", y_out, -1); check("round_neg_sat", sat_flag, 0);
        send(16383);   check("round_half", y_out, 0); check("round_half_sat", sat_flag, 0);
        // saturation
        send(ONE << 31);    check("sat_hi", y_out, 32767);  check("sat_hi_flag", sat_flag, 1);
        send(-(ONE << 31)); check("sat_lo", y_out, -32768); check("sat_lo_flag", sat_flag, 1);
        idle(2);
        check("sat_count_two", sat_count, 2);

        // fill to 30 samples, then reset mid-window
        for (int i = 0; i < 25; i++) send(longint'($urandom_range(0, 1000 * 32768)) - 500 * 32768);
        idle(3);
        #2 rst = 1'b0;
        model_reset();
        #1 check_zero("rst_async");
        repeat (3) @(posedge clk);
        check_zero("rst_held");
        #1 rst = 1'b1;
        idle(1);

        // window with a single -1234 at sample 10 and random gaps
        p0 = n_peak_seen;
        for (int i = 0; i < WIN - 1; i++) begin
            send((i == 10) ? -1234 * 32768
                           : longint'($urandom_range(0, 1000 * 32768)) - 500 * 32768);
            maybe_gap(1'b1);
        end
        idle(3);
        check("no_early_peak", n_peak_seen - p0, 0);
        send(500 * 32768);
        idle(3);
        check("one_peak", n_peak_seen - p0, 1);
        check("peak_1234", peak, 1234);

        window_of(0, 1'b1);   idle(4); check("peak_zero", peak, 0);

        // hysteresis
        window_of(5000, 1'b0); idle(4); check("tone_arm", tone_det, 0);
        window_of(5000, 1'b1); idle(4); check("tone_rise", tone_det, 1);
        window_of(3000, 1'b0); idle(4); check("tone_hold_3000", tone_det, 1);
        window_of(1000, 1'b0); idle(4); check("tone_rel1", tone_det, 1);
        window_of(3000, 1'b0); idle(4); check("tone_back", tone_det, 1);
        window_of(1000, 1'b0); idle(4); check("tone_rel2", tone_det, 1);
        window_of(1000, 1'b1); idle(4); check("tone_fall", tone_det, 0);
        // thresholds are inclusive at TH_ON, exclusive at TH_OFF
        window_of(4000, 1'b0); idle(4);
        window_of(4000, 1'b0); idle(4); check("tone_on_edge", tone_det, 1);
        window_of(2000, 1'b0); idle(4);
        window_of(2000, 1'b0); idle(4); check("tone_off_edge", tone_det, 1);

        // most negative output maps to the largest magnitude
        send(-(ONE << 31));
        for (int i = 1; i < WIN; i++) send(0);
        idle(4);
        check("peak_min_neg", peak, 32767);

        // random full-range traffic
        for (int w = 0; w < 8 * WIN; w++) begin
            raw = {$urandom, $urandom};
            if ($urandom_range(0, 3) != 0) raw = raw >>> (64 - 34);
            else raw = (raw <<< (64 - IN_W)) >>> (64 - IN_W);
            send(raw);
            maybe_gap(1'b1);
        end
        idle(4);

        // clip counter must stick at its maximum
        while (m_clips < 65538) send(($urandom_range(0, 1) == 1) ? (ONE << 36) : -(ONE << 36));
        idle(4);
        check("sat_count_stick", sat_count, 65535);

        idle(4);
        check("yq_drained", yq.size(), 0);
        check("pq_drained", pq.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fir_out_conditioner.md
Name: fir_out_conditioner

Overview:
- Downstream stage of the 51-tap band-pass FIR.
- Takes the full-precision 38-bit filter output and requantises it to 16-bit signed using round-half-up and saturation.
- Measures peak magnitude over fixed sample windows and drives a hysteretic tone-present detector.
- Keeps a saturating count of clipping events, for checking the filter gain on Artix-7.

Parameters:
- IN_W, 38, width of FIR output input.
- OUT_W, 16, width of requantised output and peak.
- SHIFT, 15, arithmetic right shift applied (Q15 coefficient scaling); must be >= 1.
- WIN, 64, valid samples per peak window; must be >= 2.
- TH_ON, 4000, peak threshold for tone-on; must be >= TH_OFF.
- TH_OFF, 2000, peak threshold for tone-off.
- HOLD, 2, consecutive qualifying windows needed to change tone state; must be >= 1.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset; active-low, asynchronous.
- in_valid  in  1  y_in carries a new FIR sample this cycle.
- y_in  in  IN_W  signed FIR output.
- y_out  out  OUT_W  signed rounded and saturated sample.
- y_valid  out  1  y_out valid strobe.
- sat_flag  out  1  y_out was clipped; qualified by y_valid.
- peak  out  OUT_W  unsigned max |y_out| of the last completed window.
- peak_valid  out  1  one-cycle pulse when peak updates.
- tone_det  out  1  tone-present indication.
- sat_count  out  16  saturating count of clip events.

Behaviour:
Reset:
- Asserting rst (low) at any time asynchronously clears every output and internal register to 0: window counter, running max, hold counter.
- FSM goes to ABSENT.
- Operation resumes on the first in_valid after rst deasserts. No partial window survives reset.

Requantise (1 cycle latency):
- On in_valid: r = (y_in + 2^(SHIFT-1)) >>> SHIFT, computed at IN_W+1 bits with no intermediate overflow.
- If r > 32767: y_out = 32767 and sat_flag = 1.
- If r < -32768: y_out = -32768 and sat_flag = 1.
- Otherwise y_out = r and sat_flag = 0.
- y_valid = in_valid delayed one cycle.
- When in_valid is low, y_valid is 0 and y_out/sat_flag hold their last values.

sat_count:
- Increments on each cycle where y_valid and sat_flag are both 1.
- Sticks at 65535; no wrap.

Peak window:
- m = |y_out|; m = 32767 when y_out = -32768.
- On each y_valid, running max runs over the window; the window counter counts 0..WIN-1.
- On the y_valid that completes the window (counter = WIN-1):
  - peak <= max(running, m) and peak_valid = 1 on the next cycle, for one cycle only.
  - Running max clears to 0 and the counter wraps to 0, so the next sample starts a fresh window.
- Gaps in valid stall the counter and running max. They never close a window.
- peak holds its value between updates.

Tone FSM:
- Evaluated only on peak_valid cycles. Comparisons are unsigned.
- "on" means peak >= TH_ON. "off" means peak < TH_OFF. peak == TH_OFF is not "off".
- ABSENT (tone_det = 0):
  - on: hold = 1; go to PRESENT if HOLD = 1, else ARMING.
- ARMING (tone_det = 0):
  - on: hold++; go to PRESENT when hold reaches HOLD.
  - not on: hold = 0; go to ABSENT.
- PRESENT (tone_det = 1):
  - off: hold = 1; go to ABSENT if HOLD = 1, else RELEASING.
- RELEASING (tone_det = 1):
  - off: hold++; go to ABSENT when hold reaches HOLD.
  - not off: hold = 0; go to PRESENT.
- tone_det changes in the cycle after the deciding peak_valid. It is registered from the FSM state.

Test Plan:
- Reset mid-window: feed 30 valid samples, pulse rst low for 3 cycles, then feed 64 samples → exactly one peak_valid, 64 samples after release. All outputs read 0 during reset, regardless of clk.
- Rounding: y_in = 49152 → y_out = 2; y_in = -49152 → y_out = -1; y_in = 16383 → y_out = 0. All with sat_flag = 0, one cycle after in_valid.
- Saturation: y_in = 2^31 → y_out = 32767 and sat_flag = 1; y_in = -2^31 → y_out = -32768 and sat_flag = 1; sat_count = 2. Preload near the limit, then 3 clips → sat_count stays 65535.
- Window/peak: 64 valid samples, all |y| ≤ 500 except sample 10 = -1234 (post-shift), with random in_valid gaps → one peak_valid pulse and peak = 1234. The next window of zeros → peak = 0.
- Hysteresis (HOLD = 2): window peaks 5000, 5000 → tone_det rises after the 2nd window. Then 3000 → stays 1. Then 1000, 3000, 1000, 1000 → falls only after the final pair.
- Edge values: peak = 4000 counts as on. peak = 2000 does not count as off. y_out = -32768 yields peak = 32767.
